bin_switch_sched: RTL and testbench

//  Sequences bin switching for the SAT engine. Queues bin requests, writes back the resident bin through

---
 rtl/bin_switch_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_bin_switch_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_switch_sched.sv
// bin_switch_sched
//   Bin-switch sequencer for the SAT engine bin manager. Queues bin requests,
//   writes the resident bin back through update_bin, then loads the requested
//   bin through load_bin, steering the BRAM port mux between the two movers.
//   A watchdog aborts a switch whose mover never answers.
//
//   Optional feature macro: BIN_SWITCH_SKIP_RELOAD_EN
//     defined   -> a request for the bin that is already resident completes
//                  immediately with no store or load.
//     undefined -> every request runs the full store + load sequence.
module bin_switch_sched #(
    parameter int WIDTH_BIN_ID   = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int WIDTH_TO       = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic [WIDTH_BIN_ID-1:0] req_bin_i,
    output logic                    req_ready_o,
    input  logic                    flush_i,
    output logic                    start_update_o,
    input  logic                    done_update_i,
    output logic                    start_load_o,
    output logic [WIDTH_BIN_ID-1:0] request_bin_num_o,
    input  logic                    done_load_i,
    output logic [1:0]              ram_sel_o,
    output logic [WIDTH_BIN_ID-1:0] cur_bin_o,
    output logic                    cur_bin_valid_o,
    output logic                    busy_o,
    output logic                    switch_done_o,
    output logic                    err_timeout_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [WIDTH_TO-1:0] WD_LAST  = WIDTH_TO'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        STORE      = 3'd1,
        STORE_WAIT = 3'd2,
        LOAD       = 3'd3,
        LOAD_WAIT  = 3'd4,
        DONE       = 3'd5
    } state_t;

    logic [WIDTH_BIN_ID-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ready_q, ready_d;

    state_t                  state_q, state_d;
    logic [WIDTH_BIN_ID-1:0] tgt_q, tgt_d;
    logic [WIDTH_BIN_ID-1:0] curBin_q, curBin_d;
    logic                    curValid_q, curValid_d;
    logic                    err_q, err_d;
    logic [WIDTH_TO-1:0]     wd_q, wd_d;

    logic                    pushEn;
    logic                    popEn;
    logic [WIDTH_BIN_ID-1:0] headBin;

    // A flush discards the push of the same cycle; the FSM pops only while idle.
    assign pushEn  = req_valid_i & ready_q & ~flush_i;
    assign popEn   = (state_q == IDLE) && (count_q != '0);
    assign headBin = fifoMem_q[rdPtr_q];

    // Queue pointer/count next state; flush empties the queue outright.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({pushEn, popEn})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d < CNT_FULL);
    end

    // Queue storage; entries beyond the count are never read, so no reset.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem_q[wrPtr_q] <= req_bin_i;
        end
    end

    // Queue bookkeeping registers, including the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // Switch sequencer next state, target/resident bookkeeping and watchdog.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        curBin_d   = curBin_q;
        curValid_d = curValid_q;
        err_d      = err_q;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (popEn) begin
                    tgt_d = headBin;
`ifdef BIN_SWITCH_SKIP_RELOAD_EN
                    if (curValid_q && (headBin == curBin_q)) begin
                        state_d = DONE;
                    end else if (curValid_q) begin
                        state_d = STORE;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    if (curValid_q) begin
                        state_d = STORE;
                    end else begin
                        state_d = LOAD;
                    end
`endif
                end
            end
            STORE: begin
                wd_d    = '0;
                state_d = STORE_WAIT;
            end
            STORE_WAIT: begin
                if (done_update_i) begin
                    state_d = LOAD;
                end else if (wd_q == WD_LAST) begin
                    err_d      = 1'b1;
                    curValid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    wd_d = wd_q + WIDTH_TO'(1);
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (done_load_i) begin
                    state_d = DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d      = 1'b1;
                    curValid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    wd_d = wd_q + WIDTH_TO'(1);
                end
            end
            DONE: begin
                curBin_d   = tgt_q;
                curValid_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any switch in progress silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            curBin_q   <= '0;
            curValid_q <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            curBin_q   <= curBin_d;
            curValid_q <= curValid_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
        end
    end

    // BRAM owner decode: the mux follows the state, so it only moves on state edges.
    always_comb begin
        ram_sel_o = 2'd0;
        case (state_q)
            STORE, STORE_WAIT: ram_sel_o = 2'd1;
            LOAD, LOAD_WAIT:   ram_sel_o = 2'd2;
            default:           ram_sel_o = 2'd0;
        endcase
    end

    assign req_ready_o       = ready_q;
    assign start_update_o    = (state_q == STORE);
    assign start_load_o      = (state_q == LOAD);
    assign request_bin_num_o = tgt_q;
    assign cur_bin_o         = curBin_q;
    assign cur_bin_valid_o   = curValid_q;
    assign busy_o            = (state_q != IDLE);
    assign switch_done_o     = (state_q == DONE);
    assign err_timeout_o     = err_q;

endmodule

// File: tb/tb_bin_switch_sched.sv
// tb_bin_switch_sched
//   Directed scenarios followed by randomized traffic for bin_switch_sched.
//   A queue-based reference model predicts every output each cycle.
module tb_bin_switch_sched;

    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam int TO    = 40;
    localparam int WTO   = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid_i;
    logic [W-1:0] req_bin_i;
    logic         req_ready_o;
    logic         flush_i;
    logic         start_update_o;
    logic         done_update_i;
    logic         start_load_o;
    logic [W-1:0] request_bin_num_o;
    logic         done_load_i;
    logic [1:0]   ram_sel_o;
    logic [W-1:0] cur_bin_o;
    logic         cur_bin_valid_o;
    logic         busy_o;
    logic         switch_done_o;
    logic         err_timeout_o;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    bin_switch_sched #(
        .WIDTH_BIN_ID   (W),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .WIDTH_TO       (WTO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid_i),
        .req_bin_i         (req_bin_i),
        .req_ready_o       (req_ready_o),
        .flush_i           (flush_i),
        .start_update_o    (start_update_o),
        .done_update_i     (done_update_i),
        .start_load_o      (start_load_o),
        .request_bin_num_o (request_bin_num_o),
        .done_load_i       (done_load_i),
        .ram_sel_o         (ram_sel_o),
        .cur_bin_o         (cur_bin_o),
        .cur_bin_valid_o   (cur_bin_valid_o),
        .busy_o            (busy_o),
        .switch_done_o     (switch_done_o),
        .err_timeout_o     (err_timeout_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net in case a bounded wait is ever miscounted.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout got stuck expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending requests in a queue, the switch in progress
    // described by its phase and the cycles spent waiting for a mover.
    // ------------------------------------------------------------------
    typedef enum int {P_IDLE, P_STORE, P_STORE_WAIT, P_LOAD, P_LOAD_WAIT, P_DONE} phase_t;

    int     mq[$];
    phase_t mPhase  = P_IDLE;
    int     mTgt    = 0;
    int     mCur    = 0;
    bit     mValid  = 1'b0;
    bit     mErr    = 1'b0;
    bit     mReady  = 1'b0;
    int     mElapsed = 0;

    // Advance the model on each active edge using the inputs the DUT samples.
    always @(posedge clk) begin : referenceModel
        bit     canPush;
        phase_t nxt;
        if (rst) begin
            mq.delete();
            mPhase   = P_IDLE;
            mTgt     = 0;
            mCur     = 0;
            mValid   = 1'b0;
            mErr     = 1'b0;
            mReady   = 1'b0;
            mElapsed = 0;
        end else begin
            canPush = mReady;
            nxt     = mPhase;
            case (mPhase)
                P_IDLE: begin
                    if (mq.size() > 0) begin
                        mTgt = mq.pop_front();
`ifdef BIN_SWITCH_SKIP_RELOAD_EN
                        if (mValid && (mTgt == mCur)) nxt = P_DONE;
                        else nxt = mValid ? P_STORE : P_LOAD;
`else
                        nxt = mValid ? P_STORE : P_LOAD;
`endif
                    end
                end
                P_STORE: begin
                    mElapsed = 0;
                    nxt = P_STORE_WAIT;
                end
                P_STORE_WAIT: begin
                    if (done_update_i) nxt = P_LOAD;
                    else if (mElapsed + 1 >= TO) begin
                        mErr = 1'b1; mValid = 1'b0; nxt = P_IDLE;
                    end else mElapsed++;
                end
                P_LOAD: begin
                    mElapsed = 0;
                    nxt = P_LOAD_WAIT;
                end
                P_LOAD_WAIT: begin
                    if (done_load_i) nxt = P_DONE;
                    else if (mElapsed + 1 >= TO) begin
                        mErr = 1'b1; mValid = 1'b0; nxt = P_IDLE;
                    end else mElapsed++;
                end
                P_DONE: begin
                    mCur   = mTgt;
                    mValid = 1'b1;
                    nxt    = P_IDLE;
                end
                default: nxt = P_IDLE;
            endcase
            if (flush_i) mq.delete();
            else if (req_valid_i && canPush) mq.push_back(int'(req_bin_i));
            mReady = (mq.size() < DEPTH);
            mPhase = nxt;
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin : compareProcess
        int expSel;
        if (checkEn) begin
            expSel = (mPhase == P_STORE || mPhase == P_STORE_WAIT) ? 1 :
                     (mPhase == P_LOAD  || mPhase == P_LOAD_WAIT)  ? 2 : 0;
            checkOutput("model req_ready_o",       req_ready_o,       mReady);
            checkOutput("model start_update_o",    start_update_o,    mPhase == P_STORE);
            checkOutput("model start_load_o",      start_load_o,      mPhase == P_LOAD);
            checkOutput("model ram_sel_o",         ram_sel_o,         expSel);
            checkOutput("model request_bin_num_o", request_bin_num_o, mTgt);
            checkOutput("model cur_bin_o",         cur_bin_o,         mCur);
            checkOutput("model cur_bin_valid_o",   cur_bin_valid_o,   mValid);
            checkOutput("model busy_o",            busy_o,            mPhase != P_IDLE);
            checkOutput("model switch_done_o",     switch_done_o,     mPhase == P_DONE);
            checkOutput("model err_timeout_o",     err_timeout_o,     mErr);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: drive inputs for one cycle, return at next negedge.
    // ------------------------------------------------------------------
    task automatic applyStimulus(input bit v, input int b, input bit f, input bit du, input bit dl);
        req_valid_i   = v;
        req_bin_i     = W'(b);
        flush_i       = f;
        done_update_i = du;
        done_load_i   = dl;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit probe(input int which);
        case (which)
            0:       return start_update_o | start_load_o;
            1:       return start_load_o;
            2:       return switch_done_o;
            4:       return start_update_o;
            default: return err_timeout_o;
        endcase
    endfunction

    task automatic waitFor(input int which, input int maxc, input string name);
        int n = 0;
        while (!probe(which) && n < maxc) begin
            idleCycle();
            n++;
        end
        checkOutput({name, " seen"}, probe(which), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " req_ready_o"},       req_ready_o, 0);
        checkOutput({tag, " start_update_o"},    start_update_o, 0);
        checkOutput({tag, " start_load_o"},      start_load_o, 0);
        checkOutput({tag, " request_bin_num_o"}, request_bin_num_o, 0);
        checkOutput({tag, " ram_sel_o"},         ram_sel_o, 0);
        checkOutput({tag, " cur_bin_o"},         cur_bin_o, 0);
        checkOutput({tag, " cur_bin_valid_o"},   cur_bin_valid_o, 0);
        checkOutput({tag, " busy_o"},            busy_o, 0);
        checkOutput({tag, " switch_done_o"},     switch_done_o, 0);
        checkOutput({tag, " err_timeout_o"},     err_timeout_o, 0);
    endtask

    // Drive one switch to completion from IDLE/STORE/LOAD with literal checks.
    task automatic serveSwitch(input int bin, input bit expStore, input bit flushMid);
        waitFor(0, 40, "switch start");
        checkOutput("start_update_o pulse", start_update_o, expStore);
        if (expStore) begin
            checkOutput("store ram_sel_o", ram_sel_o, 1);
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
            checkOutput("store pulse one cycle", start_update_o, 0);
            repeat (2) begin
                idleCycle();
                checkOutput("store_wait ram_sel_o", ram_sel_o, 1);
                checkOutput("no load pulse while storing", start_load_o, 0);
            end
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
            waitFor(1, 10, "load start");
        end
        checkOutput("start_load_o pulse", start_load_o, 1);
        checkOutput("request_bin_num_o", request_bin_num_o, bin);
        checkOutput("load ram_sel_o", ram_sel_o, 2);
        idleCycle();
        checkOutput("load pulse one cycle", start_load_o, 0);
        checkOutput("load_wait ram_sel_o", ram_sel_o, 2);
        idleCycle();
        checkOutput("request_bin_num_o stable", request_bin_num_o, bin);
        if (flushMid) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("switch_done_o", switch_done_o, 1);
        checkOutput("done ram_sel_o", ram_sel_o, 0);
        idleCycle();
        checkOutput("cur_bin_o", cur_bin_o, bin);
        checkOutput("cur_bin_valid_o", cur_bin_valid_o, 1);
        checkOutput("switch_done one cycle", switch_done_o, 0);
    endtask

    // Main stimulus sequence.
    initial begin
        int n;
        bit stall;
        rst = 1'b1;
        req_valid_i = 1'b0; req_bin_i = '0; flush_i = 1'b0;
        done_update_i = 1'b0; done_load_i = 1'b0;
        @(negedge clk);
        idleCycle();
        checkEn = 1'b1;
        checkAllZero("reset");
        rst = 1'b0;
        idleCycle();
        checkOutput("ready after reset", req_ready_o, 1);

        $display("[TB] cold load of bin 5");
        applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
        checkOutput("idle before pop", busy_o, 0);
        idleCycle();
        checkOutput("cold start_load_o", start_load_o, 1);
        checkOutput("cold request_bin_num_o", request_bin_num_o, 5);
        checkOutput("cold no start_update_o", start_update_o, 0);
        checkOutput("cold ram_sel_o", ram_sel_o, 2);
        idleCycle();
        checkOutput("cold load pulse one cycle", start_load_o, 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("cold switch_done_o", switch_done_o, 1);
        idleCycle();
        checkOutput("cold cur_bin_o", cur_bin_o, 5);
        checkOutput("cold cur_bin_valid_o", cur_bin_valid_o, 1);
        checkOutput("cold busy_o", busy_o, 0);

        $display("[TB] switch 5 -> 9");
        applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0);
        serveSwitch(9, 1'b1, 1'b0);

        $display("[TB] queue fill, overflow and flush");
        applyStimulus(1'b1, 11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4, 1'b0, 1'b0, 1'b0);
        checkOutput("ready low when full", req_ready_o, 0);
        applyStimulus(1'b1, 6, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("bin 11 start_load_o", start_load_o, 1);
        checkOutput("bin 11 request", request_bin_num_o, 11);
        idleCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("bin 11 switch_done_o", switch_done_o, 1);
        idleCycle();
        checkOutput("bin 11 resident", cur_bin_o, 11);
        checkOutput("full at idle pop", req_ready_o, 0);
        applyStimulus(1'b1, 15, 1'b0, 1'b0, 1'b0);
        checkOutput("ready after pop at full", req_ready_o, 1);
        serveSwitch(1, 1'b1, 1'b0);
        serveSwitch(2, 1'b1, 1'b0);
        applyStimulus(1'b1, 8, 1'b0, 1'b0, 1'b0);
        serveSwitch(3, 1'b1, 1'b0);
        serveSwitch(4, 1'b1, 1'b1);
        repeat (10) idleCycle();
        checkOutput("flush left nothing queued", busy_o, 0);
        checkOutput("flush kept resident", cur_bin_o, 4);

        $display("[TB] watchdog abort in LOAD_WAIT");
        applyStimulus(1'b1, 20, 1'b0, 1'b0, 1'b0);
        waitFor(4, 10, "timeout store start");
        idleCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        idleCycle();
        n = 0;
        while (!err_timeout_o && n < TO + 20) begin
            idleCycle();
            n++;
        end
        checkOutput("timeout latency", n, TO);
        checkOutput("timeout valid cleared", cur_bin_valid_o, 0);
        checkOutput("timeout ram_sel_o", ram_sel_o, 0);
        checkOutput("timeout busy_o", busy_o, 0);
        applyStimulus(1'b1, 21, 1'b0, 1'b0, 1'b0);
        serveSwitch(21, 1'b0, 1'b0);
        checkOutput("timeout flag sticky", err_timeout_o, 1);

        $display("[TB] request for resident bin 21");
        applyStimulus(1'b1, 21, 1'b0, 1'b0, 1'b0);
`ifdef BIN_SWITCH_SKIP_RELOAD_EN
        idleCycle();
        checkOutput("skip switch_done_o", switch_done_o, 1);
        checkOutput("skip no start_update_o", start_update_o, 0);
        checkOutput("skip no start_load_o", start_load_o, 0);
        idleCycle();
        checkOutput("skip resident", cur_bin_o, 21);
        checkOutput("skip valid", cur_bin_valid_o, 1);
`else
        serveSwitch(21, 1'b1, 1'b0);
`endif

        $display("[TB] reset during LOAD_WAIT");
        applyStimulus(1'b1, 30, 1'b0, 1'b0, 1'b0);
        waitFor(4, 10, "reset-test store start");
        idleCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("in LOAD_WAIT before reset", ram_sel_o, 2);
        rst = 1'b1;
        idleCycle();
        checkAllZero("mid reset");
        rst = 1'b0;
        idleCycle();
        applyStimulus(1'b1, 31, 1'b0, 1'b0, 1'b0);
        serveSwitch(31, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 4000; cyc++) begin
            stall = ((cyc / 300) % 4) == 3;
            rst = ($urandom_range(0, 699) == 0);
            applyStimulus(($urandom_range(0, 2) == 0),
                          int'($urandom_range(0, 5)),
                          ($urandom_range(0, 59) == 0),
                          !stall && ($urandom_range(0, 4) == 0),
                          !stall && ($urandom_range(0, 4) == 0));
        end
        rst = 1'b0;
        repeat (5) idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
